// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency ROM and buffers words with their PCs
// in a small prefetch queue. Execute-stage redirects flush all speculative fetches.
module fetch_prefetch_unit #(
  parameter int                    Data_Width        = 32,
  parameter int                    Address_Width_ROM = 12,
  parameter logic [Data_Width-1:0] Reset_PC          = '0,
  parameter int                    FIFO_Depth        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PCsrc,
  input  logic                         JalrSel,
  input  logic [Data_Width-1:0]        branchPC,
  input  logic [Data_Width-1:0]        ImmOp,
  input  logic [Data_Width-1:0]        ALUout,
  output logic                         imemRe,
  output logic [Address_Width_ROM-1:0] imemAddr,
  input  logic [Data_Width-1:0]        imemData,
  output logic                         instrValid,
  input  logic                         instrReady,
  output logic [Data_Width-1:0]        instr,
  output logic [Data_Width-1:0]        pcOut,
  output logic [Data_Width-1:0]        newPC,
  output logic                         misalign
);

  localparam int PtrW = (FIFO_Depth > 1) ? $clog2(FIFO_Depth) : 1;
  localparam int CntW = $clog2(FIFO_Depth) + 1;

  logic [Data_Width-1:0] fetch_pc;
  logic [Data_Width-1:0] req_pc;
  logic                  inflight;
  logic                  kill;
  logic                  misalign_q;

  logic [Data_Width-1:0] q_instr [FIFO_Depth];
  logic [Data_Width-1:0] q_pc    [FIFO_Depth];
  logic [PtrW-1:0]       rd_ptr;
  logic [PtrW-1:0]       wr_ptr;
  logic [CntW-1:0]       count;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CntW:0]         occupancy;
  logic [Data_Width-1:0] target;
  logic [Data_Width-1:0] target_aligned;

  assign instrValid = (count != '0);
  assign pop        = instrValid & instrReady;

  // A redirect in the response cycle wins over the push; kill guards a response launched before a redirect.
  assign push = inflight & ~kill & ~PCsrc;

  // Credit counts the outstanding read so a returning word always has a free slot.
  assign occupancy = {1'b0, count} + (CntW+1)'(inflight) - (CntW+1)'(pop);
  assign issue     = ~rst & ~PCsrc & (occupancy < (CntW+1)'(FIFO_Depth));

  assign target = JalrSel ? (ALUout & {{(Data_Width-1){1'b1}}, 1'b0})
                          : (branchPC + ImmOp);
  assign target_aligned = {target[Data_Width-1:2], 2'b00};

  assign imemRe   = issue;
  assign imemAddr = fetch_pc[Address_Width_ROM-1:0];
  assign misalign = misalign_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= Reset_PC;
      req_pc     <= Reset_PC;
      inflight   <= 1'b0;
      kill       <= 1'b0;
      misalign_q <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      inflight   <= issue;
      kill       <= PCsrc & inflight;
      misalign_q <= PCsrc & (|target[1:0]);

      if (PCsrc) begin
        fetch_pc <= target_aligned;
      end else if (issue) begin
        fetch_pc <= fetch_pc + Data_Width'(4);
      end

      if (issue) begin
        req_pc <= fetch_pc;
      end

      if (PCsrc) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PtrW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PtrW'(1);
        end
        count <= count + CntW'(push) - CntW'(pop);
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; count alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push & ~rst) begin
      q_instr[wr_ptr] <= imemData;
      q_pc[wr_ptr]    <= req_pc;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    instr = '0;
    pcOut = '0;
    newPC = '0;
    if (instrValid) begin
      instr = q_instr[rd_ptr];
      pcOut = q_pc[rd_ptr];
      newPC = q_pc[rd_ptr] + Data_Width'(4);
    end
  end

endmodule
